// File: rtl/undertale_pkg.sv
// Shared types and constants for the Undertale sprite path: facing direction,
// keyboard codes, scene ids and the Frisk frame-selection helper.
package undertale_pkg;

  typedef enum logic [1:0] {
    DIR_DOWN  = 2'd0,
    DIR_UP    = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  localparam logic [7:0]  KEY_W = 8'd26;
  localparam logic [7:0]  KEY_A = 8'd4;
  localparam logic [7:0]  KEY_S = 8'd22;
  localparam logic [7:0]  KEY_D = 8'd7;

  localparam logic [3:0]  SCENE_OVERWORLD   = 4'd3;
  localparam logic [23:0] FRISK_TRANSPARENT = 24'he607f8;
  localparam int          FRISK_NUM_FRAMES  = 10;

  // Up/down walks use a 3-pose cycle (stand, left foot, stand, right foot);
  // left/right simply alternate two poses.
  function automatic logic [3:0] frame_of(input dir_t dir, input logic [1:0] step);
    logic [3:0] base;
    base = 4'd0;
    case (dir)
      DIR_DOWN:  base = 4'd0;
      DIR_UP:    base = 4'd3;
      DIR_LEFT:  base = 4'd6;
      DIR_RIGHT: base = 4'd8;
      default:   base = 4'd0;
    endcase
    if (dir == DIR_LEFT || dir == DIR_RIGHT) begin
      frame_of = base + {3'd0, step[0]};
    end else if (step == 2'd3) begin
      frame_of = base + 4'd2;
    end else begin
      frame_of = base + {3'd0, step[0]};
    end
  endfunction

endpackage

// File: rtl/frisk_anim_fsm.sv
// Frisk walk animation: frame_clk edge detect, facing direction, walk-cycle
// step counter and the registered frame index.
module frisk_anim_fsm
  import undertale_pkg::*;
#(
  parameter int         ANIM_DIV = 8,
  parameter logic [3:0] SCENE_ID = SCENE_OVERWORLD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic [3:0] status,
  output logic [3:0] frame_sel
);

  localparam int               DIV_W    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ANIM_DIV - 1);

  logic             frame_clk_d_r;
  logic             tick_r;
  dir_t             dir_r;
  logic [1:0]       step_r;
  logic [DIV_W-1:0] div_cnt_r;
  logic [3:0]       frame_sel_r;

  dir_t             key_dir_s;
  logic             key_valid_s;
  logic             moving_s;
  dir_t             dir_nxt_s;
  logic [1:0]       step_nxt_s;
  logic [DIV_W-1:0] div_nxt_s;

  // Keycode decode into a walking direction.
  always_comb begin
    key_valid_s = 1'b1;
    key_dir_s   = DIR_DOWN;
    case (keycode)
      KEY_W:   key_dir_s = DIR_UP;
      KEY_A:   key_dir_s = DIR_LEFT;
      KEY_S:   key_dir_s = DIR_DOWN;
      KEY_D:   key_dir_s = DIR_RIGHT;
      default: key_valid_s = 1'b0;
    endcase
  end

  // Next animation state; only a tick may move it, and a direction change
  // while walking keeps the cycle phase so the gait never restarts.
  always_comb begin
    moving_s   = key_valid_s && (status == SCENE_ID);
    dir_nxt_s  = dir_r;
    step_nxt_s = step_r;
    div_nxt_s  = div_cnt_r;
    if (tick_r) begin
      if (moving_s) begin
        dir_nxt_s = key_dir_s;
        if (div_cnt_r == DIV_LAST) begin
          div_nxt_s  = {DIV_W{1'b0}};
          step_nxt_s = step_r + 2'd1;
        end else begin
          div_nxt_s  = div_cnt_r + DIV_W'(1);
          step_nxt_s = step_r;
        end
      end else begin
        div_nxt_s  = {DIV_W{1'b0}};
        step_nxt_s = 2'd0;
      end
    end else begin
      dir_nxt_s  = dir_r;
      step_nxt_s = step_r;
      div_nxt_s  = div_cnt_r;
    end
  end

  // State register; reset wins over a coincident tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_clk_d_r <= 1'b0;
      tick_r        <= 1'b0;
      dir_r         <= DIR_DOWN;
      step_r        <= 2'd0;
      div_cnt_r     <= {DIV_W{1'b0}};
      frame_sel_r   <= 4'd0;
    end else begin
      frame_clk_d_r <= frame_clk;
      tick_r        <= frame_clk & ~frame_clk_d_r;
      dir_r         <= dir_nxt_s;
      step_r        <= step_nxt_s;
      div_cnt_r     <= div_nxt_s;
      frame_sel_r   <= frame_of(dir_nxt_s, step_nxt_s);
    end
  end

  assign frame_sel = frame_sel_r;

endmodule

// File: rtl/frisk_sprite_render.sv
// Frisk sprite renderer: animation state plus a two-stage pixel pipe that
// broadcasts the ROM address and picks/keys the colour of the current frame.
module frisk_sprite_render
  import undertale_pkg::*;
#(
  parameter int          ANIM_DIV    = 8,
  parameter logic [23:0] TRANSPARENT = FRISK_TRANSPARENT,
  parameter logic [3:0]  SCENE_ID    = SCENE_OVERWORLD,
  parameter int          ADDR_W      = 20
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  frame_clk,
  input  logic [7:0]            keycode,
  input  logic [3:0]            status,
  input  logic                  is_frisk,
  input  logic [ADDR_W-1:0]     frisk_address,
  output logic [ADDR_W-1:0]     rom_address,
  input  logic [9:0][23:0]      rom_color,
  output logic [3:0]            frame_sel,
  output logic                  pixel_on,
  output logic [23:0]           pixel_color
);

  logic [ADDR_W-1:0] rom_address_r;
  logic              v1_r;
  logic [3:0]        f1_r;
  logic              pixel_on_r;
  logic [23:0]       pixel_color_r;
  logic [23:0]       sel_color_s;
  logic              opaque_s;

  frisk_anim_fsm #(
    .ANIM_DIV (ANIM_DIV),
    .SCENE_ID (SCENE_ID)
  ) u_anim (
    .clk       (Clk),
    .reset     (Reset),
    .frame_clk (frame_clk),
    .keycode   (keycode),
    .status    (status),
    .frame_sel (frame_sel)
  );

  // Colour of the frame snapshotted with this pixel, so a mid-pipe frame
  // change cannot mix two frames on one pixel.
  always_comb begin
    sel_color_s = 24'd0;
    if (f1_r < 4'(FRISK_NUM_FRAMES)) begin
      sel_color_s = rom_color[f1_r];
    end else begin
      sel_color_s = 24'd0;
    end
    opaque_s = v1_r && (sel_color_s != TRANSPARENT);
  end

  // Pixel pipe: stage 1 issues the ROM address, stage 2 captures the colour.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_address_r <= {ADDR_W{1'b0}};
      v1_r          <= 1'b0;
      f1_r          <= 4'd0;
      pixel_on_r    <= 1'b0;
      pixel_color_r <= 24'd0;
    end else begin
      rom_address_r <= frisk_address;
      v1_r          <= is_frisk && (status == SCENE_ID);
      f1_r          <= frame_sel;
      pixel_on_r    <= opaque_s;
      pixel_color_r <= opaque_s ? sel_color_s : 24'd0;
    end
  end

  assign rom_address = rom_address_r;
  assign pixel_on    = pixel_on_r;
  assign pixel_color = pixel_color_r;

endmodule

// File: tb/tb_frisk_sprite_render.sv
// Directed bench for frisk_sprite_render: walk animation sequences, pixel pipe
// latency and keying, frame snapshot, scene gating and reset mid-walk.
module tb_frisk_sprite_render;

  logic             Clk;
  logic             Reset;
  logic             frame_clk;
  logic [7:0]       keycode;
  logic [3:0]       status;
  logic             is_frisk;
  logic [19:0]      frisk_address;
  logic [19:0]      rom_address;
  logic [9:0][23:0] rom_color;
  logic [3:0]       frame_sel;
  logic             pixel_on;
  logic [23:0]      pixel_color;

  int checks = 0;
  int errors = 0;

  // Reference model state: facing direction (0 down,1 up,2 left,3 right) and
  // number of consecutive moving ticks since the last idle tick.
  int cur_dir = 0;
  int m_cnt   = 0;
  int frame_tab [16] = '{0, 1, 0, 2, 3, 4, 3, 5, 6, 7, 6, 7, 8, 9, 8, 9};

  frisk_sprite_render dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_clk     (frame_clk),
    .keycode       (keycode),
    .status        (status),
    .is_frisk      (is_frisk),
    .frisk_address (frisk_address),
    .rom_address   (rom_address),
    .rom_color     (rom_color),
    .frame_sel     (frame_sel),
    .pixel_on      (pixel_on),
    .pixel_color   (pixel_color)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int key_dir(input logic [7:0] k);
    case (k)
      8'd26:   return 1;
      8'd4:    return 2;
      8'd22:   return 0;
      8'd7:    return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_tick(input logic [7:0] k, input logic [3:0] st);
    int d;
    d = key_dir(k);
    if (st == 4'd3 && d >= 0) begin
      cur_dir = d;
      m_cnt++;
    end else begin
      m_cnt = 0;
    end
  endtask

  function automatic int exp_frame();
    return frame_tab[cur_dir * 4 + (m_cnt / 8) % 4];
  endfunction

  task automatic pulse();
    frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic tick_chk(input logic [7:0] k, input string tag);
    keycode = k;
    pulse();
    model_tick(k, status);
    chk(tag, 32'(frame_sel), 32'(exp_frame()));
  endtask

  task automatic distinct_colors();
    for (int i = 0; i < 10; i++) rom_color[i] = 24'h0a0000 | 24'(i);
  endtask

  initial begin
    Reset = 1'b1; frame_clk = 1'b0; keycode = 8'd0; status = 4'd3;
    is_frisk = 1'b0; frisk_address = 20'd0;
    distinct_colors();
    repeat (3) @(negedge Clk);
    chk("rst_frame_sel", 32'(frame_sel), 32'd0);
    chk("rst_pixel_on", 32'(pixel_on), 32'd0);
    chk("rst_pixel_color", 32'(pixel_color), 32'd0);
    chk("rst_rom_address", 32'(rom_address), 32'd0);
    Reset = 1'b0;
    @(negedge Clk);

    for (int i = 0; i < 5; i++) tick_chk(8'd0, "idle_down");

    for (int i = 0; i < 32; i++) tick_chk(8'd7, "walk_right");
    tick_chk(8'd0, "release_right");

    for (int i = 0; i < 24; i++) tick_chk(8'd22, "walk_down");
    for (int i = 0; i < 16; i++) tick_chk(8'd26, "switch_up");
    tick_chk(8'd0, "release_up");

    // Pixel pipe latency and transparency keying (current frame is 3).
    for (int i = 0; i < 10; i++) rom_color[i] = 24'hffc90e;
    is_frisk = 1'b1; frisk_address = 20'h00123;
    @(negedge Clk);
    chk("s1_rom_address", 32'(rom_address), 32'h123);
    @(negedge Clk);
    chk("s2_pixel_on", 32'(pixel_on), 32'd1);
    chk("s2_pixel_color", 32'(pixel_color), 32'hffc90e);
    rom_color[3] = 24'he607f8;
    @(negedge Clk);
    chk("transp_pixel_on", 32'(pixel_on), 32'd0);
    chk("transp_pixel_color", 32'(pixel_color), 32'd0);
    is_frisk = 1'b0;
    distinct_colors();
    repeat (2) @(negedge Clk);
    chk("not_frisk_pixel_on", 32'(pixel_on), 32'd0);

    // Tick lands while a pixel sits in stage 1: that pixel keeps frame 3.
    keycode = 8'd7; frame_clk = 1'b1; is_frisk = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    model_tick(8'd7, 4'd3);
    chk("mid_frame_sel", 32'(frame_sel), 32'(exp_frame()));
    @(negedge Clk);
    chk("mid_old_color", 32'(pixel_color), 32'h0a0003);
    chk("mid_old_on", 32'(pixel_on), 32'd1);
    @(negedge Clk);
    chk("mid_new_color", 32'(pixel_color), 32'h0a0008);
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);

    // Leaving the overworld: pixels off, animation falls back to idle pose.
    status = 4'd2;
    repeat (2) @(negedge Clk);
    chk("scene_pixel_on", 32'(pixel_on), 32'd0);
    chk("scene_pixel_color", 32'(pixel_color), 32'd0);
    for (int i = 0; i < 3; i++) tick_chk(8'd7, "scene_no_anim");

    // Reset mid-walk at step 3 facing left, with a tick pending.
    status = 4'd3;
    for (int i = 0; i < 24; i++) tick_chk(8'd4, "walk_left");
    chk("pre_rst_pixel_on", 32'(pixel_on), 32'd1);
    chk("pre_rst_pixel_color", 32'(pixel_color), 32'h0a0007);
    frame_clk = 1'b1;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("midrst_frame_sel", 32'(frame_sel), 32'd0);
    chk("midrst_pixel_on", 32'(pixel_on), 32'd0);
    chk("midrst_pixel_color", 32'(pixel_color), 32'd0);
    chk("midrst_rom_address", 32'(rom_address), 32'd0);
    Reset = 1'b0; frame_clk = 1'b0;
    cur_dir = 0; m_cnt = 0;
    @(negedge Clk);
    chk("post_rst_frame_sel", 32'(frame_sel), 32'd0);
    chk("post_rst_pixel_on", 32'(pixel_on), 32'd0);
    repeat (2) @(negedge Clk);
    chk("post_rst_pixel_color", 32'(pixel_color), 32'h0a0000);
    tick_chk(8'd0, "post_rst_idle");
    tick_chk(8'd4, "post_rst_left");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
